dm_dma_arbiter: RTL and testbench
=================================

DM_DMA_ARBITER -- requirements
Module: dm_dma_arbiter

Interface
REQ-001 SHALL have parameter DMA_SIZE, default 17, DM address width.
REQ-002 SHALL have parameter DMD_SIZE, default 16, DM data width.
REQ-003 SHALL have parameter LEN_W, default 16, burst-length width.
REQ-004 SHALL have port clk, input, 1, clock; all state changes on posedge clk.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports core_dm_cslt / core_dm_wrb, input, 1 each, core DM select / write-not-read.
REQ-007 SHALL have ports core_dm_add, input, DMA_SIZE, core address; core_dt, input, DMD_SIZE, core write data, valid one cycle after its select.
REQ-008 SHALL have ports dma_start, input, 1; dma_dir, input, 1 (1 = write into DM); dma_base, input, DMA_SIZE; dma_len, input, LEN_W.
REQ-009 SHALL have port dma_abort, input, 1, which terminates the burst.
REQ-010 SHALL have ports dma_wdata, input, DMD_SIZE; dma_wack, output, 1, pulses in the cycle dma_wdata is consumed.
REQ-011 SHALL have ports dma_rdata, output, DMD_SIZE; dma_rvalid, output, 1.
REQ-012 SHALL have ports dma_busy, output, 1; dma_done, output, 1, single-cycle pulse.
REQ-013 SHALL have memory-side outputs ps_dm_cslt, ps_dm_wrb, dg_dm_add, bc_dt, and memory-side input dm_bc_dt, DMD_SIZE.

Function
REQ-014 SHALL implement FSM IDLE, RUN, DONE.
REQ-015 IDLE -> RUN SHALL occur on dma_start with dma_len != 0, latching base, len and dir.
REQ-016 IDLE -> DONE SHALL occur on dma_start with dma_len == 0, with no memory access.
REQ-017 RUN -> DONE SHALL occur after the last granted beat or on dma_abort.
REQ-018 DONE -> IDLE SHALL occur unconditionally after one cycle.
REQ-019 dma_done SHALL be 1 exactly in DONE; dma_busy SHALL be 1 in RUN and DONE.
REQ-020 dma_start SHALL be ignored unless in IDLE.
REQ-021 Core SHALL have absolute priority: when core_dm_cslt=1, the memory outputs pass core signals combinationally that cycle.
REQ-022 DMA SHALL be granted a beat in RUN only in cycles with core_dm_cslt=0.
REQ-023 On each granted beat: ps_dm_cslt=1, ps_dm_wrb=dir, dg_dm_add=current address.
REQ-024 On each granted beat the address SHALL increment modulo 2^DMA_SIZE, wrapping from all-ones to 0, and the remaining count SHALL decrement.
REQ-025 In a DMA write beat, dma_wack=1 and dma_wdata SHALL be registered; the registered value drives bc_dt in the following cycle (memory write happens at select+1).
REQ-026 bc_dt SHALL select the registered DMA data when the previous cycle was a DMA write beat, otherwise core_dt.
REQ-027 dma_rvalid SHALL be 1 the cycle after a DMA read beat; dma_rdata = dm_bc_dt combinationally.
REQ-028 In cycles with no requester, ps_dm_cslt and ps_dm_wrb SHALL be 0, and dg_dm_add SHALL hold its last value.
REQ-029 dma_abort in the same cycle as a grant SHALL suppress that beat.
REQ-030 A pending write-data or rvalid cycle from an earlier beat SHALL still complete after abort.
REQ-031 dma_abort SHALL have no effect in IDLE.

Reset
REQ-032 reset=0 SHALL force IDLE and clear all registers (address, count, dir, write-data register, beat-history flags) asynchronously.
REQ-033 During reset, all outputs SHALL be 0, except memory-side outputs, which still forward core signals combinationally.
REQ-034 Reset asserted mid-burst SHALL abandon the burst with no dma_done pulse.

Structure
REQ-035 Package dm_ctrl_pkg SHALL hold the FSM state encoding and the default DMA_SIZE/DMD_SIZE/LEN_W constants.
REQ-036 Sub-module dm_burst_counter SHALL hold the address/count registers with load, increment and last-beat flag; the FSM and port mux SHALL stay in dm_dma_arbiter.

Verification
REQ-037 The bench SHALL cover: write burst base=0x1FFFE, len=4, no core traffic -> addresses 1FFFE,1FFFF,00000,00001 on consecutive cycles, dma_done 1 cycle after the last beat.
REQ-038 The bench SHALL cover: read burst base=0x10, len=3, core_dm_cslt=1 in the 2nd cycle -> core address passes in that cycle, DMA beats at 0x10,0x11,0x12 spread over 4 cycles, 3 rvalid pulses.
REQ-039 The bench SHALL cover: DMA write beat to 0x20 followed by a core read select -> bc_dt carries DMA data in the following cycle; the core read is unaffected.
REQ-040 The bench SHALL cover: dma_start with dma_len=0 -> dma_done next cycle, no ps_dm_cslt.
REQ-041 The bench SHALL cover: dma_abort on the 2nd beat of a len=8 burst -> exactly 1 beat issued, then DONE, then IDLE.
REQ-042 The bench SHALL cover: reset asserted mid-burst -> all outputs 0 immediately, no dma_done, and a new dma_start accepted after release.

Source files
------------

// File: rtl/dm_ctrl_pkg.sv
// Purpose: shared definitions for the DM controller slice: default widths of
//          the DM address/data buses and the DMA burst-length field, plus the
//          state encoding of the DMA arbiter FSM.
// Ports:   none (package).
package dm_ctrl_pkg;

  localparam int DMA_SIZE_DEF = 17;  // DM address width
  localparam int DMD_SIZE_DEF = 16;  // DM data width
  localparam int LEN_W_DEF    = 16;  // burst-length width

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } dm_state_e;

endpackage

// File: rtl/dm_burst_counter.sv
// Purpose: address / remaining-beat counter for one DMA burst.
// Ports:   clk, reset (async active-low)
//          load_i  - latch base_i / len_i as the start of a new burst
//          inc_i   - one beat granted: address +1 (wraps), count -1
//          base_i  - burst start address, len_i - burst length in beats
//          addr_o  - address of the next beat
//          last_o  - the next beat is the final one of the burst
module dm_burst_counter
  import dm_ctrl_pkg::*;
#(
  parameter int DMA_SIZE = DMA_SIZE_DEF,
  parameter int LEN_W    = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic                inc_i,
  input  logic [DMA_SIZE-1:0] base_i,
  input  logic [LEN_W-1:0]    len_i,
  output logic [DMA_SIZE-1:0] addr_o,
  output logic                last_o
);

  logic [DMA_SIZE-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;

  // Next-state: load has priority over increment; address wraps naturally.
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      addr_d = base_i;
      cnt_d  = len_i;
    end else if (inc_i) begin
      addr_d = addr_q + DMA_SIZE'(1);
      cnt_d  = cnt_q - LEN_W'(1);
    end else begin
      addr_d = addr_q;
      cnt_d  = cnt_q;
    end
  end

  // Address / count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/dm_dma_arbiter.sv
// Purpose: shares the data-memory port between the core and a DMA burst
//          engine. The core always wins; DMA beats use the idle cycles.
// Ports:   clk, reset (async active-low)
//          core_dm_cslt/core_dm_wrb/core_dm_add/core_dt - core request
//          dma_start/dma_dir/dma_base/dma_len/dma_abort  - DMA control
//          dma_wdata/dma_wack                            - DMA write data
//          dma_rdata/dma_rvalid                          - DMA read data
//          dma_busy/dma_done                             - DMA status
//          ps_dm_cslt/ps_dm_wrb/dg_dm_add/bc_dt/dm_bc_dt - memory side
module dm_dma_arbiter
  import dm_ctrl_pkg::*;
#(
  parameter int DMA_SIZE = DMA_SIZE_DEF,
  parameter int DMD_SIZE = DMD_SIZE_DEF,
  parameter int LEN_W    = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                core_dm_cslt,
  input  logic                core_dm_wrb,
  input  logic [DMA_SIZE-1:0] core_dm_add,
  input  logic [DMD_SIZE-1:0] core_dt,
  input  logic                dma_start,
  input  logic                dma_dir,
  input  logic [DMA_SIZE-1:0] dma_base,
  input  logic [LEN_W-1:0]    dma_len,
  input  logic                dma_abort,
  input  logic [DMD_SIZE-1:0] dma_wdata,
  output logic                dma_wack,
  output logic [DMD_SIZE-1:0] dma_rdata,
  output logic                dma_rvalid,
  output logic                dma_busy,
  output logic                dma_done,
  output logic                ps_dm_cslt,
  output logic                ps_dm_wrb,
  output logic [DMA_SIZE-1:0] dg_dm_add,
  output logic [DMD_SIZE-1:0] bc_dt,
  input  logic [DMD_SIZE-1:0] dm_bc_dt
);

  dm_state_e           state_q, state_d;
  logic                load_s, grant_s, last_s;
  logic [DMA_SIZE-1:0] beat_addr_s;
  logic                dir_q, dir_d;
  logic                wr_beat_q, wr_beat_d;
  logic                rd_beat_q, rd_beat_d;
  logic [DMD_SIZE-1:0] wdata_q, wdata_d;
  logic [DMA_SIZE-1:0] hold_add_q;

  // A beat goes out only in RUN, when the core is quiet and no abort is raised.
  assign grant_s = (state_q == ST_RUN) && !core_dm_cslt && !dma_abort;

  dm_burst_counter #(
    .DMA_SIZE(DMA_SIZE),
    .LEN_W   (LEN_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load_i(load_s),
    .inc_i (grant_s),
    .base_i(dma_base),
    .len_i (dma_len),
    .addr_o(beat_addr_s),
    .last_o(last_s)
  );

  // FSM next state; a zero-length start skips RUN and never touches memory.
  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dma_start) begin
          load_s  = (dma_len != '0);
          state_d = (dma_len != '0) ? ST_RUN : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (dma_abort || (grant_s && last_s)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Beat-history next state: what the data phase of the following cycle owes.
  always_comb begin
    dir_d     = load_s ? dma_dir : dir_q;
    wr_beat_d = grant_s && dir_q;
    rd_beat_d = grant_s && !dir_q;
    if (wr_beat_d) begin
      wdata_d = dma_wdata;
    end else begin
      wdata_d = wdata_q;
    end
  end

  // State, direction, write-data and beat-history registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      dir_q      <= 1'b0;
      wr_beat_q  <= 1'b0;
      rd_beat_q  <= 1'b0;
      wdata_q    <= '0;
      hold_add_q <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      wr_beat_q  <= wr_beat_d;
      rd_beat_q  <= rd_beat_d;
      wdata_q    <= wdata_d;
      hold_add_q <= dg_dm_add;
    end
  end

  // Memory-side mux: core first, then a DMA beat, else idle with address held.
  always_comb begin
    ps_dm_cslt = 1'b0;
    ps_dm_wrb  = 1'b0;
    dg_dm_add  = hold_add_q;
    if (core_dm_cslt) begin
      ps_dm_cslt = 1'b1;
      ps_dm_wrb  = core_dm_wrb;
      dg_dm_add  = core_dm_add;
    end else if (grant_s) begin
      ps_dm_cslt = 1'b1;
      ps_dm_wrb  = dir_q;
      dg_dm_add  = beat_addr_s;
    end else begin
      ps_dm_cslt = 1'b0;
      ps_dm_wrb  = 1'b0;
      dg_dm_add  = hold_add_q;
    end
  end

  // Write data trails its select by one cycle, so the data bus follows history.
  assign bc_dt      = wr_beat_q ? wdata_q : core_dt;
  assign dma_wack   = grant_s && dir_q;
  assign dma_rvalid = rd_beat_q;
  // Read data is a straight wire from memory, held at 0 while in reset.
  assign dma_rdata  = reset ? dm_bc_dt : '0;
  assign dma_busy   = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign dma_done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_dm_dma_arbiter.sv
module tb_dm_dma_arbiter;

  localparam int DMA_SIZE = 17;
  localparam int DMD_SIZE = 16;
  localparam int LEN_W    = 16;
  localparam int ADDR_MOD = 1 << DMA_SIZE;

  logic                clk = 1'b0;
  logic                reset;
  logic                core_dm_cslt, core_dm_wrb;
  logic [DMA_SIZE-1:0] core_dm_add;
  logic [DMD_SIZE-1:0] core_dt;
  logic                dma_start, dma_dir, dma_abort;
  logic [DMA_SIZE-1:0] dma_base;
  logic [LEN_W-1:0]    dma_len;
  logic [DMD_SIZE-1:0] dma_wdata, dma_rdata, bc_dt, dm_bc_dt;
  logic                dma_wack, dma_rvalid, dma_busy, dma_done;
  logic                ps_dm_cslt, ps_dm_wrb;
  logic [DMA_SIZE-1:0] dg_dm_add;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: burst described by base, length and beats issued so far.
  int                  m_phase;   // 0 idle, 1 bursting, 2 completion cycle
  int                  m_base, m_len, m_issued;
  logic                m_dir;
  logic [DMA_SIZE-1:0] m_last_add;
  logic                m_wr_pend, m_rd_pend;
  logic [DMD_SIZE-1:0] m_wdata;

  dm_dma_arbiter #(.DMA_SIZE(DMA_SIZE), .DMD_SIZE(DMD_SIZE), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .core_dm_cslt(core_dm_cslt), .core_dm_wrb(core_dm_wrb),
    .core_dm_add(core_dm_add), .core_dt(core_dt),
    .dma_start(dma_start), .dma_dir(dma_dir), .dma_base(dma_base),
    .dma_len(dma_len), .dma_abort(dma_abort),
    .dma_wdata(dma_wdata), .dma_wack(dma_wack),
    .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .dma_busy(dma_busy), .dma_done(dma_done),
    .ps_dm_cslt(ps_dm_cslt), .ps_dm_wrb(ps_dm_wrb),
    .dg_dm_add(dg_dm_add), .bc_dt(bc_dt), .dm_bc_dt(dm_bc_dt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_phase = 0; m_base = 0; m_len = 0; m_issued = 0; m_dir = 1'b0;
    m_last_add = '0; m_wr_pend = 1'b0; m_rd_pend = 1'b0; m_wdata = '0;
  endtask

  // Called just after a negedge with control inputs set; checks, then advances.
  task automatic cycle();
    logic                grant, e_cslt, e_wrb;
    logic [DMA_SIZE-1:0] cur, e_add;
    core_dt   = DMD_SIZE'($urandom);
    dma_wdata = DMD_SIZE'($urandom);
    dm_bc_dt  = DMD_SIZE'($urandom);
    #1;
    if (!reset) model_clear();
    grant = reset && (m_phase == 1) && !core_dm_cslt && !dma_abort;
    cur   = DMA_SIZE'((m_base + m_issued) % ADDR_MOD);
    e_cslt = core_dm_cslt || grant;
    e_wrb  = core_dm_cslt ? core_dm_wrb : (grant ? m_dir : 1'b0);
    e_add  = core_dm_cslt ? core_dm_add : (grant ? cur : m_last_add);
    check_eq("ps_dm_cslt", 32'(ps_dm_cslt), 32'(e_cslt));
    check_eq("ps_dm_wrb",  32'(ps_dm_wrb),  32'(e_wrb));
    check_eq("dg_dm_add",  32'(dg_dm_add),  32'(e_add));
    check_eq("bc_dt",      32'(bc_dt),      32'(m_wr_pend ? m_wdata : core_dt));
    check_eq("dma_wack",   32'(dma_wack),   32'(grant && m_dir));
    check_eq("dma_rvalid", 32'(dma_rvalid), 32'(m_rd_pend));
    check_eq("dma_rdata",  32'(dma_rdata),  32'(reset ? dm_bc_dt : 16'h0000));
    check_eq("dma_busy",   32'(dma_busy),   32'(m_phase != 0));
    check_eq("dma_done",   32'(dma_done),   32'(m_phase == 2));
    if (reset) begin
      m_last_add = e_add;
      m_wr_pend  = grant && m_dir;
      m_rd_pend  = grant && !m_dir;
      if (grant && m_dir) m_wdata = dma_wdata;
      case (m_phase)
        0: if (dma_start) begin
             m_base = int'(dma_base); m_len = int'(dma_len);
             m_dir = dma_dir; m_issued = 0;
             m_phase = (dma_len == '0) ? 2 : 1;
           end
        1: begin
             if (grant) m_issued++;
             if (dma_abort || (m_issued == m_len)) m_phase = 2;
           end
        default: m_phase = 0;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    core_dm_cslt = 1'b0; core_dm_wrb = 1'b0; core_dm_add = '0;
    dma_start = 1'b0; dma_abort = 1'b0;
  endtask

  task automatic start(input logic dir, input logic [DMA_SIZE-1:0] base, input logic [LEN_W-1:0] len);
    dma_start = 1'b1; dma_dir = dir; dma_base = base; dma_len = len;
    cycle();
    dma_start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; quiet(); dma_dir = 1'b0; dma_base = '0; dma_len = '0;
    core_dt = '0; dma_wdata = '0; dm_bc_dt = '0;
    model_clear();
    @(negedge clk);
    // Reset state, with core traffic forwarded during reset.
    cycle();
    core_dm_cslt = 1'b1; core_dm_wrb = 1'b1; core_dm_add = 17'h0ABCD;
    cycle();
    quiet();
    cycle();
    reset = 1'b1;
    cycle();

    // Write burst wrapping through the top of the address space.
    start(1'b1, 17'h1FFFE, 16'd4);
    repeat (6) cycle();

    // Read burst with a core access stealing the second cycle.
    start(1'b0, 17'h00010, 16'd3);
    cycle();
    core_dm_cslt = 1'b1; core_dm_wrb = 1'b1; core_dm_add = 17'h05555;
    cycle();
    quiet();
    repeat (5) cycle();

    // Single write beat followed by a core read: bc_dt still carries DMA data.
    start(1'b1, 17'h00020, 16'd1);
    cycle();
    core_dm_cslt = 1'b1; core_dm_wrb = 1'b0; core_dm_add = 17'h00100;
    cycle();
    quiet();
    repeat (3) cycle();

    // Zero-length burst.
    start(1'b1, 17'h00040, 16'd0);
    repeat (3) cycle();

    // Abort on the second beat of an eight-beat burst.
    start(1'b1, 17'h00050, 16'd8);
    cycle();
    dma_abort = 1'b1;
    cycle();
    dma_abort = 1'b0;
    repeat (3) cycle();

    // Reset in the middle of a burst, then a fresh burst.
    start(1'b0, 17'h00060, 16'd8);
    repeat (2) cycle();
    reset = 1'b0;
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
    start(1'b1, 17'h00070, 16'd2);
    repeat (4) cycle();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      core_dm_cslt = ($urandom_range(0, 99) < 30);
      core_dm_wrb  = 1'($urandom);
      core_dm_add  = DMA_SIZE'($urandom);
      dma_start    = ($urandom_range(0, 99) < 20);
      dma_dir      = 1'($urandom);
      dma_base     = ($urandom_range(0, 3) == 0) ? DMA_SIZE'(ADDR_MOD - 2) : DMA_SIZE'($urandom);
      dma_len      = LEN_W'($urandom_range(0, 6));
      dma_abort    = ($urandom_range(0, 99) < 5);
      reset        = ($urandom_range(0, 199) != 0);
      cycle();
    end
    reset = 1'b1; quiet();
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
